bus_gate_arbiter: RTL and testbench
===================================

Name: bus_gate_arbiter

Overview:
- Sequences ownership of the 16-bit internal CPU bus among four drivers: MARMUX, PC, MDR and ALU.
- Replaces ad-hoc gate decoding with a registered arbiter. It produces strictly one-hot (or all-zero) GateMARMUX/GatePC/GateMDR/GateALU, which feed the existing priority bus mux directly.
- Each requester asks for the bus and holds it for a programmed number of cycles.
- Arbitration is round-robin so no driver starves.

Parameters:
- LEN_W, 2, width of each per-requester hold-length field; hold = Len+1 cycles (1..4 at default).
- RESET_PTR, 0, round-robin pointer value after Reset (index with highest priority first).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- Req  input  4  request per source; bit0 MARMUX, bit1 PC, bit2 MDR, bit3 ALU.
- Len  input  4*LEN_W  hold length per source; field i = Len[i*LEN_W +: LEN_W]; sampled only at grant.
- GateMARMUX  output  1  bus gate for MARMUX (bit0 owner).
- GatePC  output  1  bus gate for PC (bit1 owner).
- GateMDR  output  1  bus gate for MDR (bit2 owner).
- GateALU  output  1  bus gate for ALU (bit3 owner).
- Owner  output  2  index of current owner; valid only while Busy.
- Busy  output  1  some gate is asserted this cycle.
- Done  output  4  one-hot; bit i high on the final gated cycle of owner i.

Behaviour:
- All outputs are registered; no combinational path from Req to gates.
- Reset values (synchronous, any state, including mid-transfer):
  - state = IDLE, all gates 0, Busy 0, Owner 0, Done 0.
  - ptr = RESET_PTR, cnt = 0.
- Round-robin pick:
  - Search order is ptr, ptr+1, ... mod 4.
  - On grant to index k: ptr <= k+1 mod 4, so the just-served source becomes lowest priority.
- IDLE:
  - If Req != 0 at a rising edge, grant the picked k: gate k = 1 from the next cycle (latency 1), cnt <= Len field k, state <= OWN.
  - If Req == 0, stay in IDLE.
- OWN:
  - Gate k stays high while cnt counts down by 1 per cycle.
  - The last gated cycle is the one with cnt == 0; Done[k] = 1 in exactly that cycle.
  - At the edge ending the last cycle, re-arbitrate on the current Req, including k still high, at lowest priority.
    - Winner found: switch gates to the winner in the very next cycle, back-to-back, no idle cycle.
    - No winner: go to IDLE, all gates 0.
- Early release: if Req[k] = 0 at any edge in OWN before the last cycle:
  - Gates drop next cycle; Done is not pulsed.
  - Re-arbitrate as above in the same edge.
- Len changes while in OWN are ignored.
- Req bits for non-owners are only sampled at arbitration edges; glitches between those edges are ignored.
- Invariant: at most one gate high in any cycle; Busy == OR of gates; Owner matches the high gate.

Optional Feature:
- Macro: BUS_TURNAROUND_EN.
  - Defined: every ownership end (normal or early release) passes through a GAP state for one cycle with all gates 0, Busy 0. Arbitration is evaluated at the edge leaving GAP, using the same ptr rule. Back-to-back handoff is impossible.
  - Undefined: GAP does not exist and handoff is back-to-back as described in Behaviour.

Decomposition:
- Package lc3_bus_pkg holds:
  - typedef enum logic [1:0] {IDLE, OWN, GAP} bus_arb_state_t;
  - constants SRC_MARMUX=0, SRC_PC=1, SRC_MDR=2, SRC_ALU=3;
  - NUM_BUS_SRC=4.
- One combinational sub-module, rr_pick: inputs req[3:0] and ptr[1:0]; outputs valid and idx[1:0]. It is instantiated once in bus_gate_arbiter.

Test Plan:
- Reset then Req=4'b0010, Len PC=2 → GatePC high for cycles 1..3 after the sampling edge, Done[1] in cycle 3, then IDLE with gates 0; ptr=2.
- From reset, Req=4'b1111, all Len=0 → grant order MARMUX, PC, MDR, ALU, MARMUX, each for 1 cycle, back-to-back, never two gates high.
- PC owns with Len=3; drop Req[1] after the 2nd gated cycle → GatePC low next cycle, Done stays 0, pending ALU request granted the following cycle.
- Single requester MDR holding Req high with Len=1 → re-granted continuously: GateMDR stays high, Done[2] pulses every 2nd cycle.
- Assert Reset mid-transfer (ALU, cnt=2) → next cycle all gates 0, Busy 0, Done 0; after Reset drops, Req=4'b1001 grants MARMUX first.
- With BUS_TURNAROUND_EN, Req=4'b0011, Len=0 → MARMUX 1 cycle, one all-zero cycle, PC 1 cycle. Without the macro → MARMUX then PC in adjacent cycles.

Source files
------------

// File: rtl/lc3_bus_pkg.sv
// Shared types and source indices for the LC-3 internal bus gate arbiter.
// The GAP state is only reachable when BUS_TURNAROUND_EN is defined.
package lc3_bus_pkg;

  typedef enum logic [1:0] {IDLE, OWN, GAP} bus_arb_state_t;

  localparam int NUM_BUS_SRC = 4;

  localparam logic [1:0] SRC_MARMUX = 2'd0;
  localparam logic [1:0] SRC_PC     = 2'd1;
  localparam logic [1:0] SRC_MDR    = 2'd2;
  localparam logic [1:0] SRC_ALU    = 2'd3;

  function automatic logic [NUM_BUS_SRC-1:0] src_onehot(input logic [1:0] idx);
    src_onehot      = '0;
    src_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req bit searching
// upward from ptr, wrapping modulo 4.
module rr_pick
  import lc3_bus_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] idx
);

  // Walk from the farthest offset down so the nearest requester wins last.
  always_comb begin
    valid = 1'b0;
    idx   = ptr;
    for (int i = NUM_BUS_SRC - 1; i >= 0; i--) begin
      if (req[ptr + 2'(i)]) begin
        valid = 1'b1;
        idx   = ptr + 2'(i);
      end
    end
  end

endmodule

// File: rtl/bus_gate_arbiter.sv
// Registered round-robin owner of the 16-bit CPU bus (MARMUX/PC/MDR/ALU gates).
// Define BUS_TURNAROUND_EN to insert a one-cycle all-gates-off GAP after every ownership.
module bus_gate_arbiter
  import lc3_bus_pkg::*;
#(
  parameter int LEN_W     = 2,
  parameter int RESET_PTR = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [3:0]           Req,
  input  logic [4*LEN_W-1:0]   Len,
  output logic                 GateMARMUX,
  output logic                 GatePC,
  output logic                 GateMDR,
  output logic                 GateALU,
  output logic [1:0]           Owner,
  output logic                 Busy,
  output logic [3:0]           Done
);

  bus_arb_state_t   state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gate_q, gate_d;
  logic [3:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             arb_en;
  logic             pick_valid;
  logic [1:0]       pick_idx;

  rr_pick u_pick (
    .req   (Req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    arb_en  = 1'b0;
    case (state_q)
      IDLE: arb_en = 1'b1;
      OWN: begin
        // Ownership ends on the last counted cycle or when the owner withdraws early.
        if (cnt_q == '0 || !Req[owner_q]) begin
`ifdef BUS_TURNAROUND_EN
          state_d = GAP;
`else
          state_d = IDLE;
          arb_en  = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q - LEN_W'(1);
        end
      end
`ifdef BUS_TURNAROUND_EN
      GAP: begin
        state_d = IDLE;
        arb_en  = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase

    // A grant rotates the pointer past the winner so it becomes lowest priority.
    if (arb_en && pick_valid) begin
      state_d = OWN;
      owner_d = pick_idx;
      cnt_d   = Len[pick_idx*LEN_W +: LEN_W];
      ptr_d   = pick_idx + 2'd1;
    end

    busy_d = (state_d == OWN);
    gate_d = busy_d ? src_onehot(owner_d) : '0;
    done_d = (busy_d && cnt_d == '0) ? src_onehot(owner_d) : '0;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= 2'(RESET_PTR);
      cnt_q   <= '0;
      gate_q  <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign GateMARMUX = gate_q[SRC_MARMUX];
  assign GatePC     = gate_q[SRC_PC];
  assign GateMDR    = gate_q[SRC_MDR];
  assign GateALU    = gate_q[SRC_ALU];
  assign Owner      = owner_q;
  assign Busy       = busy_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_bus_gate_arbiter.sv
// Scoreboard bench for bus_gate_arbiter: a per-cycle ownership model pushes the
// expected outputs of every cycle; a negedge monitor pops and compares them.
module tb_bus_gate_arbiter;

  localparam int LEN_W     = 2;
  localparam int RESET_PTR = 0;
  localparam int EW        = 12; // {owner_care, gates[3:0], busy, owner[1:0], done[3:0]}

  logic             Clk;
  logic             Reset;
  logic [3:0]       Req;
  logic [4*LEN_W-1:0] Len;
  logic             GateMARMUX, GatePC, GateMDR, GateALU;
  logic [1:0]       Owner;
  logic             Busy;
  logic [3:0]       Done;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  logic [EW-1:0] exp_q[$];

  bus_gate_arbiter #(.LEN_W(LEN_W), .RESET_PTR(RESET_PTR)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Len        (Len),
    .GateMARMUX (GateMARMUX),
    .GatePC     (GatePC),
    .GateMDR    (GateMDR),
    .GateALU    (GateALU),
    .Owner      (Owner),
    .Busy       (Busy),
    .Done       (Done)
  );

  // Clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: who holds the bus and how many gated cycles remain.
  bit         m_busy, m_gap, m_care, m_arb;
  int         m_owner, m_left, m_ptr, m_k;
  logic [3:0] m_gates, m_done;

  function automatic int rr_choose(input logic [3:0] r, input int p);
    for (int i = 0; i < 4; i++) begin
      if (r[(p + i) % 4]) return (p + i) % 4;
    end
    return -1;
  endfunction

  always @(posedge Clk) begin
    cycle++;
    if (Reset) begin
      m_busy  = 0;
      m_gap   = 0;
      m_owner = 0;
      m_left  = 0;
      m_ptr   = RESET_PTR;
      m_care  = 1;
    end else begin
      m_care = 0;
      m_arb  = 0;
      if (m_busy) begin
        if (m_left == 1 || !Req[m_owner]) begin
          m_busy = 0;
`ifdef BUS_TURNAROUND_EN
          m_gap = 1;
`else
          m_arb = 1;
`endif
        end else begin
          m_left--;
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_arb = 1;
      end else begin
        m_arb = 1;
      end
      if (m_arb) begin
        m_k = rr_choose(Req, m_ptr);
        if (m_k >= 0) begin
          m_busy  = 1;
          m_owner = m_k;
          m_left  = int'(Len[m_k*LEN_W +: LEN_W]) + 1;
          m_ptr   = (m_k + 1) % 4;
        end
      end
    end
    m_gates = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    m_done  = (m_busy && m_left == 1) ? (4'b0001 << m_owner) : 4'b0000;
    exp_q.push_back({m_busy | m_care, m_gates, m_busy, 2'(m_owner), m_done});
  end

  // Monitor / scoreboard
  logic [EW-1:0] exp_v;
  logic [3:0]    act_gates;
  bit            bad;

  always @(negedge Clk) begin
    if (exp_q.size() > 0) begin
      exp_v     = exp_q.pop_front();
      act_gates = {GateALU, GateMDR, GatePC, GateMARMUX};
      bad = (act_gates !== exp_v[10:7]) || (Busy !== exp_v[6]) || (Done !== exp_v[3:0]);
      if (exp_v[11] && (Owner !== exp_v[5:4])) bad = 1;
      checks++;
      if (bad) begin
        failures++;
        $display("FAIL outputs cyc=%0d got gates=%b busy=%b owner=%0d done=%b exp gates=%b busy=%b owner=%0d(care=%b) done=%b",
                 cycle, act_gates, Busy, Owner, Done,
                 exp_v[10:7], exp_v[6], exp_v[5:4], exp_v[11], exp_v[3:0]);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic [3:0] r, input logic [7:0] l, input int n);
    Req = r;
    Len = l;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic pulse_reset(input int n);
    Reset = 1'b1;
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;
  endtask

  // Len packing: {ALU, MDR, PC, MARMUX}, two bits each.
  initial begin
    Reset = 1'b1;
    Req   = '0;
    Len   = '0;
    repeat (3) begin
      @(posedge Clk);
      #1;
    end
    Reset = 1'b0;

    // PC alone, Len=2: three gated cycles, Done on the third, then idle.
    drive(4'b0010, 8'b00_00_10_00, 3);
    drive(4'b0000, 8'h00, 3);

    pulse_reset(1);
    // All four requesting, all Len 0: strict rotation, back-to-back.
    drive(4'b1111, 8'h00, 5);
    drive(4'b0000, 8'h00, 2);

    // PC Len=3 with ALU waiting; PC withdraws after two gated cycles.
    pulse_reset(1);
    drive(4'b0010, 8'b00_00_11_00, 1);
    drive(4'b1010, 8'b00_00_11_00, 2);
    drive(4'b1000, 8'b00_00_11_00, 3);
    drive(4'b0000, 8'h00, 2);

    // MDR alone with Len=1 held: continuous re-grant, Done every 2nd cycle.
    drive(4'b0100, 8'b00_01_00_00, 8);
    drive(4'b0000, 8'h00, 2);

    // Reset in the middle of an ALU transfer, then MARMUX and ALU together.
    drive(4'b1000, 8'b11_00_00_00, 2);
    pulse_reset(1);
    drive(4'b1001, 8'h00, 4);
    drive(4'b0000, 8'h00, 2);

    // MARMUX then PC, Len 0 (adjacent or separated by a gap).
    pulse_reset(1);
    drive(4'b0011, 8'h00, 1);
    drive(4'b0010, 8'h00, 2);
    drive(4'b0000, 8'h00, 2);

    // Len changes during ownership must be ignored.
    drive(4'b0100, 8'b00_11_00_00, 1);
    drive(4'b0100, 8'b00_00_00_00, 5);
    drive(4'b0000, 8'h00, 2);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        pulse_reset(1);
      end else if ($urandom_range(0, 3) == 0) begin
        drive(4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 1);
      end else begin
        drive(Req, 8'($urandom_range(0, 255)), 1);
      end
    end
    drive(4'b0000, 8'h00, 6);

    @(negedge Clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got %0d pending entries exp 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
